// File: rtl/reg_file_sb.sv
// reg_file_sb: 2**ADDR_W x WIDTH register file with two asynchronous read
// ports, one writeback port and a per-entry busy scoreboard.
// The scoreboard flags read-after-write hazards on in-flight writebacks.
// Optional build macro REGFILE_BYPASS_EN: a writeback is forwarded to the
// read ports and their busy flags in the same cycle. Without it, reads
// return stored contents only.
module reg_file_sb #(
   parameter int WIDTH    = 16,
   parameter int ADDR_W   = 4,
   parameter bit ZERO_REG = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] rd_addr_a,
   output logic [WIDTH-1:0]  rd_data_a,
   output logic              busy_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [WIDTH-1:0]  rd_data_b,
   output logic              busy_b,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic              iss_en,
   input  logic [ADDR_W-1:0] iss_addr,
   output logic              stall,
   input  logic              rd_use_a,
   input  logic              rd_use_b,
   output logic [ADDR_W:0]   busy_count
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam int CNT_W = ADDR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [DEPTH-1:0] busy;
   logic [DEPTH-1:0] busy_nxt;
   logic [CNT_W-1:0] busy_cnt_r;
   logic [CNT_W-1:0] busy_cnt_nxt;

   logic wr_ok;
   logic iss_ok;
   logic set_new;
   logic clr_new;

`ifdef REGFILE_BYPASS_EN
   logic hit_a;
   logic hit_b;
`endif

   // Entry 0 is hardwired to zero when ZERO_REG is set: it takes no writes
   // and can never become busy.
   function automatic logic writable(input logic [ADDR_W-1:0] addr);
      return !(ZERO_REG && (addr == '0));
   endfunction

   // Stored contents as seen by a read port, with the zero register masked.
   function automatic logic [WIDTH-1:0] stored(input logic [ADDR_W-1:0] addr);
      logic [WIDTH-1:0] val;
      val = mem[addr];
      if (!writable(addr)) begin
         val = '0;
      end
      return val;
   endfunction

   // Qualify strobes and work out the next scoreboard and its population.
   // Issue is applied after writeback so a same-address pair leaves the
   // entry busy: the newer producer is still outstanding.
   always_comb begin
      wr_ok    = wr_en & writable(wr_addr);
      iss_ok   = iss_en & writable(iss_addr);
      busy_nxt = busy;
      if (wr_ok) begin
         busy_nxt[wr_addr] = 1'b0;
      end
      if (iss_ok) begin
         busy_nxt[iss_addr] = 1'b1;
      end
      // A bit counts as newly set only if it was clear; it counts as newly
      // cleared only if it was set and no issue re-arms it this edge.
      set_new      = iss_ok & ~busy[iss_addr];
      clr_new      = wr_ok & busy[wr_addr] & ~(iss_ok & (iss_addr == wr_addr));
      busy_cnt_nxt = busy_cnt_r + CNT_W'(set_new) - CNT_W'(clr_new);
   end

   // Storage, scoreboard and busy counter; reset wins over any strobe.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy       <= '0;
         busy_cnt_r <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (wr_ok) begin
            mem[wr_addr] <= wr_data;
         end
         busy       <= busy_nxt;
         busy_cnt_r <= busy_cnt_nxt;
      end
   end

   // Read ports, busy flags and the operand-qualified stall.
   always_comb begin
`ifdef REGFILE_BYPASS_EN
      hit_a     = wr_ok && (wr_addr == rd_addr_a);
      hit_b     = wr_ok && (wr_addr == rd_addr_b);
      rd_data_a = hit_a ? wr_data : stored(rd_addr_a);
      rd_data_b = hit_b ? wr_data : stored(rd_addr_b);
      // A forwarded operand is only still busy if a new producer is being
      // issued to the same entry in this very cycle.
      busy_a    = hit_a ? (iss_ok && (iss_addr == rd_addr_a)) : busy[rd_addr_a];
      busy_b    = hit_b ? (iss_ok && (iss_addr == rd_addr_b)) : busy[rd_addr_b];
`else
      rd_data_a = stored(rd_addr_a);
      rd_data_b = stored(rd_addr_b);
      busy_a    = busy[rd_addr_a];
      busy_b    = busy[rd_addr_b];
`endif
      stall     = (busy_a & rd_use_a) | (busy_b & rd_use_b);
   end

   assign busy_count = busy_cnt_r;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed testbench for reg_file_sb (default parameters: WIDTH=16,
// ADDR_W=4, ZERO_REG=1). Follows REGFILE_BYPASS_EN the same way as the RTL.
module tb_reg_file_sb;

   logic        clk;
   logic        reset;
   logic [3:0]  rd_addr_a;
   logic [15:0] rd_data_a;
   logic        busy_a;
   logic [3:0]  rd_addr_b;
   logic [15:0] rd_data_b;
   logic        busy_b;
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [15:0] wr_data;
   logic        iss_en;
   logic [3:0]  iss_addr;
   logic        stall;
   logic        rd_use_a;
   logic        rd_use_b;
   logic [4:0]  busy_count;

   int n_vec = 0;
   int n_err = 0;

   reg_file_sb dut (
      .clk        (clk),
      .reset      (reset),
      .rd_addr_a  (rd_addr_a),
      .rd_data_a  (rd_data_a),
      .busy_a     (busy_a),
      .rd_addr_b  (rd_addr_b),
      .rd_data_b  (rd_data_b),
      .busy_b     (busy_b),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .iss_en     (iss_en),
      .iss_addr   (iss_addr),
      .stall      (stall),
      .rd_use_a   (rd_use_a),
      .rd_use_b   (rd_use_b),
      .busy_count (busy_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_en  = 1'b0;
      iss_en = 1'b0;
   endtask

   task automatic do_write(input logic [3:0] a, input logic [15:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      tick();
      idle();
   endtask

   task automatic do_issue(input logic [3:0] a);
      iss_en = 1'b1; iss_addr = a;
      tick();
      idle();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      rd_addr_a = 4'd3; rd_addr_b = 4'd7; rd_use_a = 1'b1; rd_use_b = 1'b1;
      #1;
      n_vec++;
      if (busy_count !== 5'd0) begin
         n_err++; $display("FAIL reset_count: got %0d want 0", busy_count);
      end
      n_vec++;
      if (rd_data_a !== 16'h0000) begin
         n_err++; $display("FAIL reset_data: got %h want 0000", rd_data_a);
      end
      n_vec++;
      if (stall !== 1'b0) begin
         n_err++; $display("FAIL reset_stall: got %b want 0", stall);
      end
      reset = 1'b0;
      rd_use_a = 1'b0; rd_use_b = 1'b0;
   endtask

   task automatic test_writes();
      do_write(4'd3, 16'h1234);
      do_write(4'd0, 16'hBEEF);
      rd_addr_a = 4'd3; rd_addr_b = 4'd0;
      #1;
      n_vec++;
      if (rd_data_a !== 16'h1234) begin
         n_err++; $display("FAIL write_e3: got %h want 1234", rd_data_a);
      end
      n_vec++;
      if (rd_data_b !== 16'h0000) begin
         n_err++; $display("FAIL zero_reg: got %h want 0000", rd_data_b);
      end
      n_vec++;
      if (busy_count !== 5'd0) begin
         n_err++; $display("FAIL write_count: got %0d want 0", busy_count);
      end
   endtask

   task automatic test_issue_writeback();
      do_issue(4'd5);
      rd_addr_a = 4'd5; rd_use_a = 1'b1;
      #1;
      n_vec++;
      if (busy_a !== 1'b1 || stall !== 1'b1) begin
         n_err++; $display("FAIL issue_busy: got busy=%b stall=%b want 1 1", busy_a, stall);
      end
      n_vec++;
      if (busy_count !== 5'd1) begin
         n_err++; $display("FAIL issue_count: got %0d want 1", busy_count);
      end
      rd_use_a = 1'b0;
      #1;
      n_vec++;
      if (stall !== 1'b0) begin
         n_err++; $display("FAIL unused_stall: got %b want 0", stall);
      end
      rd_use_a = 1'b1;
      tick();
      tick();
      do_write(4'd5, 16'h00A5);
      n_vec++;
      if (busy_a !== 1'b0 || stall !== 1'b0 || rd_data_a !== 16'h00A5) begin
         n_err++; $display("FAIL retire5: got busy=%b stall=%b data=%h want 0 0 00a5", busy_a, stall, rd_data_a);
      end
      n_vec++;
      if (busy_count !== 5'd0) begin
         n_err++; $display("FAIL retire5_count: got %0d want 0", busy_count);
      end
      rd_use_a = 1'b0;
   endtask

   task automatic test_same_addr();
      do_issue(4'd7);
      wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h7777;
      iss_en = 1'b1; iss_addr = 4'd7;
      tick();
      idle();
      rd_addr_a = 4'd7;
      #1;
      n_vec++;
      if (rd_data_a !== 16'h7777 || busy_a !== 1'b1) begin
         n_err++; $display("FAIL same_addr: got data=%h busy=%b want 7777 1", rd_data_a, busy_a);
      end
      n_vec++;
      if (busy_count !== 5'd1) begin
         n_err++; $display("FAIL same_count: got %0d want 1", busy_count);
      end
      // Different addresses in the same cycle: retire 7, issue 8.
      wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h0077;
      iss_en = 1'b1; iss_addr = 4'd8;
      tick();
      idle();
      rd_addr_a = 4'd7; rd_addr_b = 4'd8;
      #1;
      n_vec++;
      if (busy_a !== 1'b0 || busy_b !== 1'b1 || rd_data_a !== 16'h0077) begin
         n_err++; $display("FAIL diff_addr: got b7=%b b8=%b d7=%h want 0 1 0077", busy_a, busy_b, rd_data_a);
      end
      n_vec++;
      if (busy_count !== 5'd1) begin
         n_err++; $display("FAIL diff_count: got %0d want 1", busy_count);
      end
      do_write(4'd8, 16'h0088);
   endtask

   task automatic test_fill();
      for (int i = 1; i < 16; i++) begin
         do_issue(4'(i));
      end
      n_vec++;
      if (busy_count !== 5'd15) begin
         n_err++; $display("FAIL fill_count: got %0d want 15", busy_count);
      end
      do_issue(4'd0);
      do_issue(4'd3);
      rd_addr_b = 4'd0;
      #1;
      n_vec++;
      if (busy_count !== 5'd15 || busy_b !== 1'b0) begin
         n_err++; $display("FAIL redundant_issue: got count=%0d b0=%b want 15 0", busy_count, busy_b);
      end
      for (int i = 1; i < 16; i++) begin
         do_write(4'(i), 16'(i * 16'h0111));
      end
      rd_addr_a = 4'd15; rd_addr_b = 4'd1;
      #1;
      n_vec++;
      if (busy_count !== 5'd0) begin
         n_err++; $display("FAIL drain_count: got %0d want 0", busy_count);
      end
      n_vec++;
      if (rd_data_a !== 16'h0FFF || rd_data_b !== 16'h0111) begin
         n_err++; $display("FAIL drain_data: got %h %h want 0fff 0111", rd_data_a, rd_data_b);
      end
      do_write(4'd4, 16'hD00D);
      rd_addr_a = 4'd4;
      #1;
      n_vec++;
      if (busy_count !== 5'd0 || rd_data_a !== 16'hD00D || busy_a !== 1'b0) begin
         n_err++; $display("FAIL idle_write: got count=%0d data=%h busy=%b want 0 d00d 0", busy_count, rd_data_a, busy_a);
      end
   endtask

   task automatic test_reset_mid();
      do_write(4'd2, 16'h5555);
      for (int i = 1; i < 5; i++) begin
         do_issue(4'(i));
      end
      rd_addr_a = 4'd2;
      #1;
      n_vec++;
      if (busy_count !== 5'd4 || rd_data_a !== 16'h5555 || busy_a !== 1'b1) begin
         n_err++; $display("FAIL pre_reset: got count=%0d data=%h busy=%b want 4 5555 1", busy_count, rd_data_a, busy_a);
      end
      reset = 1'b1;
      wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'hAAAA;
      iss_en = 1'b1; iss_addr = 4'd6;
      tick();
      reset = 1'b0;
      idle();
      rd_addr_a = 4'd2; rd_addr_b = 4'd4;
      #1;
      n_vec++;
      if (rd_data_a !== 16'h0000 || rd_data_b !== 16'h0000) begin
         n_err++; $display("FAIL mid_reset_data: got %h %h want 0000 0000", rd_data_a, rd_data_b);
      end
      n_vec++;
      if (busy_count !== 5'd0 || busy_a !== 1'b0 || busy_b !== 1'b0) begin
         n_err++; $display("FAIL mid_reset_busy: got count=%0d ba=%b bb=%b want 0 0 0", busy_count, busy_a, busy_b);
      end
      rd_addr_b = 4'd6;
      #1;
      n_vec++;
      if (busy_b !== 1'b0) begin
         n_err++; $display("FAIL mid_reset_iss: got %b want 0", busy_b);
      end
   endtask

   task automatic test_bypass();
      do_issue(4'd9);
      rd_addr_a = 4'd9; rd_use_a = 1'b1; rd_use_b = 1'b0;
      wr_en = 1'b1; wr_addr = 4'd9; wr_data = 16'hCAFE;
      #1;
`ifdef REGFILE_BYPASS_EN
      n_vec++;
      if (rd_data_a !== 16'hCAFE || busy_a !== 1'b0 || stall !== 1'b0) begin
         n_err++; $display("FAIL bypass_hit: got data=%h busy=%b stall=%b want cafe 0 0", rd_data_a, busy_a, stall);
      end
`else
      n_vec++;
      if (rd_data_a !== 16'h0000 || busy_a !== 1'b1 || stall !== 1'b1) begin
         n_err++; $display("FAIL no_bypass: got data=%h busy=%b stall=%b want 0000 1 1", rd_data_a, busy_a, stall);
      end
`endif
      iss_en = 1'b1; iss_addr = 4'd9;
      #1;
      n_vec++;
      if (busy_a !== 1'b1 || stall !== 1'b1) begin
         n_err++; $display("FAIL bypass_reissue: got busy=%b stall=%b want 1 1", busy_a, stall);
      end
      tick();
      idle();
      n_vec++;
      if (rd_data_a !== 16'hCAFE || busy_count !== 5'd1) begin
         n_err++; $display("FAIL after_bypass: got data=%h count=%0d want cafe 1", rd_data_a, busy_count);
      end
      do_write(4'd9, 16'h0BAD);
      wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hFFFF;
      rd_addr_b = 4'd0; rd_use_b = 1'b1;
      #1;
      n_vec++;
      if (rd_data_b !== 16'h0000 || busy_b !== 1'b0 || busy_count !== 5'd0) begin
         n_err++; $display("FAIL zero_bypass: got data=%h busy=%b count=%0d want 0000 0 0", rd_data_b, busy_b, busy_count);
      end
      tick();
      idle();
      rd_use_a = 1'b0; rd_use_b = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      rd_addr_a = '0; rd_addr_b = '0;
      rd_use_a = 1'b0; rd_use_b = 1'b0;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      iss_en = 1'b0; iss_addr = '0;
      test_reset();
      test_writes();
      test_issue_writeback();
      test_same_addr();
      test_fill();
      test_reset_mid();
      test_bypass();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised multi-register storage block for the 16-bit datapath.
- Successor to the single 16-bit write-flagged register: generalised to 2**ADDR_W entries of WIDTH bits, with two read ports and one write port.
- Adds reset and a per-entry busy scoreboard, so the pipeline control can detect read-after-write hazards on in-flight writebacks.
- Sits between decode (read/issue) and writeback (write).

Parameters:
WIDTH, 16, data width of each entry
ADDR_W, 4, address width; entry count DEPTH = 2**ADDR_W
ZERO_REG, 1, 1 = entry 0 reads as zero, ignores writes and is never busy; 0 = entry 0 is ordinary

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
rd_addr_a  input  ADDR_W  read port A address
rd_data_a  output  WIDTH  read port A data
busy_a  output  1  entry at rd_addr_a has a pending write
rd_addr_b  input  ADDR_W  read port B address
rd_data_b  output  WIDTH  read port B data
busy_b  output  1  entry at rd_addr_b has a pending write
wr_en  input  1  writeback strobe
wr_addr  input  ADDR_W  writeback address
wr_data  input  WIDTH  writeback data
iss_en  input  1  issue strobe: marks iss_addr busy
iss_addr  input  ADDR_W  destination of the issued instruction
stall  output  1  busy_a OR busy_b, gated by rd_use_a/rd_use_b
rd_use_a  input  1  port A operand is actually consumed
rd_use_b  input  1  port B operand is actually consumed
busy_count  output  ADDR_W+1  number of entries currently busy

Behaviour:
- Reset: evaluated on the clock edge while reset=1.
  - All entries are cleared to 0.
  - All busy bits are cleared, so busy_count=0.
  - reset overrides wr_en and iss_en in the same cycle.
- Write:
  - When wr_en=1 on a rising edge, entry[wr_addr] <= wr_data and busy[wr_addr] is cleared.
  - Writes to entry 0 are discarded when ZERO_REG=1.
- Read:
  - Combinational and asynchronous. rd_data_x = entry[rd_addr_x], or 0 when ZERO_REG=1 and the address is 0.
  - The new value is visible the cycle after the write edge (one-cycle write latency) unless the bypass is enabled.
- Issue:
  - When iss_en=1 on a rising edge, busy[iss_addr] is set.
  - Ignored for entry 0 when ZERO_REG=1.
- Simultaneous wr_en and iss_en:
  - Same address: the data is written and busy ends SET, because a newer producer is outstanding.
  - Different addresses: both actions take effect.
- Read outputs:
  - busy_x = busy[rd_addr_x], combinational.
  - stall = (busy_a & rd_use_a) | (busy_b & rd_use_b).
- busy_count:
  - Registered and updated every edge: +1 for a newly set bit, -1 for a newly cleared bit, net 0 when both happen on the same address.
  - Range 0..DEPTH; it never wraps, because the set of busy bits bounds it.
- Illegal or redundant requests:
  - wr_en to an entry that is not busy is legal: the data is written and busy stays 0.
  - iss_en to an entry that is already busy leaves it busy and leaves busy_count unchanged.
- No X propagation: every output is defined from the first clock edge with reset=1 onward.

Optional Feature:
Macro: REGFILE_BYPASS_EN
- Defined: write-to-read forwarding is enabled.
  - If wr_en=1, wr_addr equals rd_addr_x, and the address is writable, then rd_data_x = wr_data combinationally in the same cycle.
  - busy_x reads 0 in that case, unless iss_en targets the same address in the same cycle.
  - stall is computed from these bypassed busy values.
- Not defined:
  - Reads return stored contents only.
  - busy_x reflects the registered busy bit, so the consumer stalls one extra cycle after writeback.

Test Plan:
- Reset and writes: reset=1 for 2 cycles, then write 0x1234 to entry 3 and 0xBEEF to entry 0 (ZERO_REG=1) -> next cycle rd_addr_a=3 gives 0x1234; rd_addr_b=0 gives 0x0000; busy_count=0.
- Issue then writeback: iss_en addr 5 -> busy_a=1 for rd_addr_a=5, rd_use_a=1 gives stall=1, busy_count=1. Two cycles later, wr_en addr 5 data 0x00A5 -> busy_a=0, data 0x00A5, busy_count=0.
- Same-address issue and writeback: busy[7] set, then wr_en and iss_en both on addr 7 -> entry 7 holds the new data, busy_a stays 1, busy_count stays 1.
- Fill all entries: issue all entries 1..15 -> busy_count=15. Retire them all -> busy_count=0, with no underflow on an extra wr_en to a non-busy entry.
- Reset mid-operation: 4 entries busy and entry 2 = 0x5555; assert reset together with wr_en addr 2 -> all entries 0 and busy_count=0 on the next cycle.
- Bypass (REGFILE_BYPASS_EN defined): wr_en addr 9 data 0xCAFE with rd_addr_a=9 in the same cycle -> rd_data_a=0xCAFE and stall=0 that cycle. Undefined: rd_data_a shows the old value, stall=1 if busy[9] was set.
